// File: rtl/iiitb_freqdiv_ctrl.sv
// ---------------------------------------------------------------------------
// iiitb_freqdiv_ctrl
//
// Controller for an external posedge clock divider. It owns the divider's
// enable and divide ratio, and accepts ratio-change requests from two
// requesters. A ratio change while the divider is running is deferred. The
// controller lets the current period finish (DRAIN), then holds the divider
// off for HALT_CYCLES cycles (HALT) while the new ratio is applied. This
// means the divider never sees its ratio change in the middle of a period.
//
// Ports
//   clkin        sole clock, all state updates on its rising edge
//   rst          synchronous active-high reset
//   run          master enable for the divider
//   req[1:0]     level request per requester, held until gnt or rej
//   ratio0/1     requested ratio for requester 0/1, valid while its req is high
//   gnt[1:0]     one-cycle accept pulse per requester
//   rej[1:0]     one-cycle reject pulse per requester (ratio below 2)
//   div_en       enable to the divider
//   div_n        divide ratio to the divider
//   busy         high while a ratio change is in progress (DRAIN or HALT)
//   period_tick  combinational, high on the last count of each divider period
// ---------------------------------------------------------------------------
module iiitb_freqdiv_ctrl #(
   parameter logic [3:0] DEFAULT_N   = 4'd2,
   parameter int         HALT_CYCLES = 2
) (
   input  logic       clkin,
   input  logic       rst,
   input  logic       run,
   input  logic [1:0] req,
   input  logic [3:0] ratio0,
   input  logic [3:0] ratio1,
   output logic [1:0] gnt,
   output logic [1:0] rej,
   output logic       div_en,
   output logic [3:0] div_n,
   output logic       busy,
   output logic       period_tick
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, HALT} state_e;

   // The halt counter is loaded with one less than the halt length. The
   // cycle in which it reads zero is therefore the last cycle with div_en low.
   localparam logic [2:0] HALT_LOAD = 3'(HALT_CYCLES - 1);

   state_e     state_q, state_d;
   logic       divEn_q, divEn_d;
   logic [3:0] divN_q, divN_d;
   logic [3:0] cnt_q, cnt_d;
   logic [3:0] pending_q, pending_d;
   logic [1:0] gnt_q, gnt_d;
   logic [1:0] rej_q, rej_d;
   logic       busy_q, busy_d;
   logic       lastServed_q, lastServed_d;
   logic [2:0] haltCnt_q, haltCnt_d;

   logic       periodTick;
   logic       arbOpen;
   logic       anyReq;
   logic       winSel;
   logic [3:0] winRatio;
   logic       winIllegal;
   logic       winSame;
   logic       winNew;

   // The shadow counter tracks the divider's own counter. This lets us know
   // when the current period ends without any feedback from the divider.
   assign periodTick = divEn_q && (cnt_q == divN_q - 4'd1);

   // Requests are only looked at in IDLE and in RUN. In RUN, a falling run
   // takes priority and suppresses arbitration on that edge. When both
   // requesters are asking, the one not served last time wins. Otherwise the
   // single asserted requester wins.
   assign arbOpen    = (state_q == IDLE) || ((state_q == RUN) && run);
   assign anyReq     = arbOpen && (req != 2'b00);
   assign winSel     = (req == 2'b11) ? ~lastServed_q : req[1];
   assign winRatio   = winSel ? ratio1 : ratio0;
   assign winIllegal = (winRatio < 4'd2);
   assign winSame    = (winRatio == divN_q);
   assign winNew     = !winIllegal && !winSame;

   // State register plus all registered outputs. Reset puts the divider back
   // on the default ratio. It also throws away any ratio still waiting in
   // pending.
   always_ff @(posedge clkin) begin
      if (rst) begin
         state_q      <= IDLE;
         divEn_q      <= 1'b0;
         divN_q       <= DEFAULT_N;
         cnt_q        <= 4'd0;
         pending_q    <= DEFAULT_N;
         gnt_q        <= 2'b00;
         rej_q        <= 2'b00;
         busy_q       <= 1'b0;
         lastServed_q <= 1'b1;
         haltCnt_q    <= 3'd0;
      end else begin
         state_q      <= state_d;
         divEn_q      <= divEn_d;
         divN_q       <= divN_d;
         cnt_q        <= cnt_d;
         pending_q    <= pending_d;
         gnt_q        <= gnt_d;
         rej_q        <= rej_d;
         busy_q       <= busy_d;
         lastServed_q <= lastServed_d;
         haltCnt_q    <= haltCnt_d;
      end
   end

   // Next-state logic.
   //  - In IDLE, a request being served holds the FSM in IDLE for that edge.
   //    The run=1 transition happens once no request is pending. This means
   //    a new IDLE ratio and the RUN entry never collide on one edge.
   //  - Every other state drops to IDLE as soon as run goes low.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (!anyReq && run) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (!run) begin
               state_d = IDLE;
            end else if (anyReq && winNew) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (!run) begin
               state_d = IDLE;
            end else if (periodTick) begin
               state_d = HALT;
            end
         end
         HALT: begin
            if (!run) begin
               state_d = IDLE;
            end else if (haltCnt_q == 3'd0) begin
               state_d = RUN;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output and datapath next values.
   //  - div_n is only ever written on an edge where div_en is already low or
   //    is being pulled low. Leaving DRAIN, whether by period end or by run
   //    dropping, always commits the pending ratio, so a granted change is
   //    never lost.
   //  - The served requester moves the round-robin pointer whether its
   //    request was granted or rejected.
   always_comb begin
      divEn_d      = divEn_q;
      divN_d       = divN_q;
      pending_d    = pending_q;
      haltCnt_d    = haltCnt_q;
      lastServed_d = lastServed_q;
      gnt_d        = 2'b00;
      rej_d        = 2'b00;

      if (!divEn_q) begin
         cnt_d = 4'd0;
      end else if (periodTick) begin
         cnt_d = 4'd0;
      end else begin
         cnt_d = cnt_q + 4'd1;
      end

      if (anyReq) begin
         lastServed_d = winSel;
         if (winIllegal) begin
            rej_d[winSel] = 1'b1;
         end else begin
            gnt_d[winSel] = 1'b1;
         end
      end

      case (state_q)
         IDLE: begin
            if (anyReq) begin
               if (winNew) begin
                  divN_d = winRatio;
               end
            end else if (run) begin
               divEn_d = 1'b1;
            end
         end
         RUN: begin
            if (!run) begin
               divEn_d = 1'b0;
            end else if (anyReq && winNew) begin
               pending_d = winRatio;
            end
         end
         DRAIN: begin
            if (!run) begin
               divEn_d = 1'b0;
               divN_d  = pending_q;
            end else if (periodTick) begin
               divEn_d   = 1'b0;
               divN_d    = pending_q;
               haltCnt_d = HALT_LOAD;
            end
         end
         HALT: begin
            if (!run) begin
               divEn_d = 1'b0;
            end else if (haltCnt_q == 3'd0) begin
               divEn_d = 1'b1;
            end else begin
               haltCnt_d = haltCnt_q - 3'd1;
            end
         end
         default: begin
            divEn_d = 1'b0;
         end
      endcase

      busy_d = (state_d == DRAIN) || (state_d == HALT);
   end

   assign gnt         = gnt_q;
   assign rej         = rej_q;
   assign div_en      = divEn_q;
   assign div_n       = divN_q;
   assign busy        = busy_q;
   assign period_tick = periodTick;

endmodule

// File: tb/tb_iiitb_freqdiv_ctrl.sv
// ---------------------------------------------------------------------------
// tb_iiitb_freqdiv_ctrl
//
// Directed scenarios followed by a randomized run. Every cycle compares every
// DUT output against a cycle model of the controller's rules. The model
// describes the controller as "running or not", "a pending ratio exists" and
// "halt cycles left". It does not use an explicit state encoding.
// ---------------------------------------------------------------------------
module tb_iiitb_freqdiv_ctrl;

   localparam logic [3:0] DEFAULT_N   = 4'd2;
   localparam int         HALT_CYCLES = 2;

   logic       clkin = 1'b0;
   logic       rst;
   logic       run;
   logic [1:0] req;
   logic [3:0] ratio0;
   logic [3:0] ratio1;
   logic [1:0] gnt;
   logic [1:0] rej;
   logic       div_en;
   logic [3:0] div_n;
   logic       busy;
   logic       period_tick;

   int testsRun    = 0;
   int testsFailed = 0;
   int stepNo      = 0;

   // Model of the controller
   bit         mEn;
   int         mN;
   int         mCnt;
   int         mPend;
   bit         mHasPend;
   int         mHaltLeft;
   bit         mRunning;
   int         mLast;
   logic [1:0] mGnt;
   logic [1:0] mRej;

   iiitb_freqdiv_ctrl #(
      .DEFAULT_N  (DEFAULT_N),
      .HALT_CYCLES(HALT_CYCLES)
   ) dut (
      .clkin      (clkin),
      .rst        (rst),
      .run        (run),
      .req        (req),
      .ratio0     (ratio0),
      .ratio1     (ratio1),
      .gnt        (gnt),
      .rej        (rej),
      .div_en     (div_en),
      .div_n      (div_n),
      .busy       (busy),
      .period_tick(period_tick)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   always #5 clkin = ~clkin;

   // Safety net so a stuck run still ends with a report
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         testsFailed++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   function automatic bit modelBusy();
      return mHasPend || (mHaltLeft > 0);
   endfunction

   function automatic bit modelTick();
      return mEn && (mCnt == mN - 1);
   endfunction

   // Advance the model by one clock edge with the given inputs
   task automatic modelStep(input bit iRst, input bit iRun, input logic [1:0] iReq,
                            input logic [3:0] iR0, input logic [3:0] iR1);
      bit tick;
      bit idle;
      bit runPlain;
      int w;
      int r;
      tick = modelTick();
      mGnt = 2'b00;
      mRej = 2'b00;
      mCnt = mEn ? (tick ? 0 : mCnt + 1) : 0;
      if (iRst) begin
         mEn = 0; mN = DEFAULT_N; mCnt = 0; mPend = DEFAULT_N; mHasPend = 0;
         mHaltLeft = 0; mRunning = 0; mLast = 1;
         return;
      end
      idle     = !mRunning;
      runPlain = mRunning && !mHasPend && (mHaltLeft == 0);
      if ((idle || (runPlain && iRun)) && (iReq != 2'b00)) begin
         if (iReq == 2'b11) w = 1 - mLast;
         else               w = iReq[1] ? 1 : 0;
         r     = (w == 1) ? int'(iR1) : int'(iR0);
         mLast = w;
         if (r < 2) begin
            mRej[w] = 1'b1;
         end else begin
            mGnt[w] = 1'b1;
            if (r != mN) begin
               if (idle) mN = r;
               else begin
                  mPend    = r;
                  mHasPend = 1;
               end
            end
         end
      end else if (idle) begin
         if (iRun) begin
            mRunning = 1;
            mEn      = 1;
         end
      end else if (!iRun) begin
         mRunning  = 0;
         mEn       = 0;
         mHaltLeft = 0;
         if (mHasPend) begin
            mN       = mPend;
            mHasPend = 0;
         end
      end else if (mHasPend && tick) begin
         mHasPend  = 0;
         mN        = mPend;
         mEn       = 0;
         mHaltLeft = HALT_CYCLES;
      end else if (mHaltLeft > 0) begin
         mHaltLeft--;
         if (mHaltLeft == 0) mEn = 1;
      end
   endtask

   task automatic checkAll();
      checkOutput($sformatf("s%0d.div_en", stepNo), 32'(div_en), 32'(mEn));
      checkOutput($sformatf("s%0d.div_n", stepNo), 32'(div_n), 32'(mN));
      checkOutput($sformatf("s%0d.gnt", stepNo), 32'(gnt), 32'(mGnt));
      checkOutput($sformatf("s%0d.rej", stepNo), 32'(rej), 32'(mRej));
      checkOutput($sformatf("s%0d.busy", stepNo), 32'(busy), 32'(modelBusy()));
      checkOutput($sformatf("s%0d.period_tick", stepNo), 32'(period_tick), 32'(modelTick()));
   endtask

   // Drive one cycle of inputs, step the model, then sample just after the edge
   task automatic applyStimulus(input bit iRst, input bit iRun, input logic [1:0] iReq,
                                input logic [3:0] iR0, input logic [3:0] iR1);
      rst    = iRst;
      run    = iRun;
      req    = iReq;
      ratio0 = iR0;
      ratio1 = iR1;
      modelStep(iRst, iRun, iReq, iR0, iR1);
      @(posedge clkin);
      #1;
      stepNo++;
      checkAll();
   endtask

   task automatic runUntilNotBusy(input string tag, input int maxCycles);
      bit expired;
      expired = 1'b1;
      for (int i = 0; i < maxCycles; i++) begin
         if (!modelBusy()) begin
            expired = 1'b0;
            break;
         end
         applyStimulus(1'b0, 1'b1, 2'b00, 4'd0, 4'd0);
      end
      if (!modelBusy()) expired = 1'b0;
      checkOutput(tag, 32'(expired), 32'd0);
   endtask

   initial begin
      int         ticks;
      bit         expired;
      bit         rRst;
      bit         rRun;
      logic [1:0] held;
      logic [3:0] hr0;
      logic [3:0] hr1;
      logic [3:0] pick;

      rst = 1'b1; run = 1'b0; req = 2'b00; ratio0 = 4'd0; ratio1 = 4'd0;
      mEn = 0; mN = DEFAULT_N; mCnt = 0; mPend = DEFAULT_N; mHasPend = 0;
      mHaltLeft = 0; mRunning = 0; mLast = 1; mGnt = 2'b00; mRej = 2'b00;

      // Reset state
      applyStimulus(1'b1, 1'b0, 2'b00, 4'd0, 4'd0);
      applyStimulus(1'b1, 1'b0, 2'b00, 4'd0, 4'd0);
      checkOutput("reset.div_n", 32'(div_n), 32'd2);
      checkOutput("reset.div_en", 32'(div_en), 32'd0);

      // Start running at the default ratio, tick every second cycle
      applyStimulus(1'b0, 1'b1, 2'b00, 4'd0, 4'd0);
      checkOutput("start.div_en", 32'(div_en), 32'd1);
      ticks = 0;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b0, 1'b1, 2'b00, 4'd0, 4'd0);
         if (period_tick) ticks++;
      end
      checkOutput("start.ticks", 32'(ticks), 32'd4);

      // Both requesters at once: requester 0 first, requester 1 after the change
      applyStimulus(1'b0, 1'b1, 2'b11, 4'd5, 4'd7);
      checkOutput("rr.first_gnt", 32'(gnt), 32'b01);
      expired = 1'b1;
      for (int i = 0; i < 30; i++) begin
         applyStimulus(1'b0, 1'b1, 2'b10, 4'd5, 4'd7);
         if (mGnt[1]) begin
            expired = 1'b0;
            break;
         end
      end
      checkOutput("rr.second_timeout", 32'(expired), 32'd0);
      checkOutput("rr.second_gnt", 32'(gnt), 32'b10);
      applyStimulus(1'b0, 1'b1, 2'b00, 4'd0, 4'd0);
      runUntilNotBusy("rr.settle_timeout", 30);
      checkOutput("rr.final_div_n", 32'(div_n), 32'd7);

      // Illegal ratio rejected, same ratio granted without a halt
      applyStimulus(1'b0, 1'b1, 2'b10, 4'd0, 4'd1);
      checkOutput("rej.rej", 32'(rej), 32'b10);
      checkOutput("rej.div_n", 32'(div_n), 32'd7);
      checkOutput("rej.div_en", 32'(div_en), 32'd1);
      applyStimulus(1'b0, 1'b1, 2'b00, 4'd0, 4'd0);
      applyStimulus(1'b0, 1'b1, 2'b10, 4'd0, 4'd7);
      checkOutput("same.gnt", 32'(gnt), 32'b10);
      checkOutput("same.busy", 32'(busy), 32'd0);
      applyStimulus(1'b0, 1'b1, 2'b00, 4'd0, 4'd0);

      // Move to ratio 4, then change to 6 from cnt=1
      applyStimulus(1'b0, 1'b1, 2'b01, 4'd4, 4'd0);
      applyStimulus(1'b0, 1'b1, 2'b00, 4'd0, 4'd0);
      runUntilNotBusy("to4.settle_timeout", 30);
      expired = 1'b1;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b0, 1'b1, 2'b00, 4'd0, 4'd0);
         if (period_tick) begin
            expired = 1'b0;
            break;
         end
      end
      checkOutput("to4.tick_timeout", 32'(expired), 32'd0);
      applyStimulus(1'b0, 1'b1, 2'b00, 4'd0, 4'd0);
      applyStimulus(1'b0, 1'b1, 2'b00, 4'd0, 4'd0);
      applyStimulus(1'b0, 1'b1, 2'b01, 4'd6, 4'd0);
      checkOutput("to6.gnt", 32'(gnt), 32'b01);
      checkOutput("to6.busy", 32'(busy), 32'd1);
      checkOutput("to6.en_drain", 32'(div_en), 32'd1);
      applyStimulus(1'b0, 1'b1, 2'b00, 4'd0, 4'd0);
      checkOutput("to6.last_tick", 32'(period_tick), 32'd1);
      checkOutput("to6.en_last", 32'(div_en), 32'd1);
      applyStimulus(1'b0, 1'b1, 2'b00, 4'd0, 4'd0);
      checkOutput("to6.halt1_en", 32'(div_en), 32'd0);
      checkOutput("to6.halt1_n", 32'(div_n), 32'd6);
      applyStimulus(1'b0, 1'b1, 2'b00, 4'd0, 4'd0);
      checkOutput("to6.halt2_en", 32'(div_en), 32'd0);
      applyStimulus(1'b0, 1'b1, 2'b00, 4'd0, 4'd0);
      checkOutput("to6.resume_en", 32'(div_en), 32'd1);
      ticks = 0;
      for (int i = 0; i < 12; i++) begin
         applyStimulus(1'b0, 1'b1, 2'b00, 4'd0, 4'd0);
         if (period_tick) ticks++;
      end
      checkOutput("to6.ticks", 32'(ticks), 32'd2);

      // Drop run during DRAIN: pending 9 is committed, no gnt/rej that edge
      applyStimulus(1'b0, 1'b1, 2'b01, 4'd9, 4'd0);
      checkOutput("drain.gnt", 32'(gnt), 32'b01);
      applyStimulus(1'b0, 1'b0, 2'b10, 4'd0, 4'd3);
      checkOutput("drain.div_en", 32'(div_en), 32'd0);
      checkOutput("drain.div_n", 32'(div_n), 32'd9);
      checkOutput("drain.gnt_none", 32'({gnt, rej}), 32'd0);
      checkOutput("drain.busy", 32'(busy), 32'd0);
      applyStimulus(1'b0, 1'b0, 2'b00, 4'd0, 4'd0);

      // Reset during HALT discards the pending ratio
      applyStimulus(1'b0, 1'b1, 2'b00, 4'd0, 4'd0);
      applyStimulus(1'b0, 1'b1, 2'b01, 4'd3, 4'd0);
      expired = 1'b1;
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b0, 1'b1, 2'b00, 4'd0, 4'd0);
         if (mHaltLeft > 0) begin
            expired = 1'b0;
            break;
         end
      end
      checkOutput("halt.reach_timeout", 32'(expired), 32'd0);
      applyStimulus(1'b1, 1'b1, 2'b00, 4'd0, 4'd0);
      checkOutput("halt_rst.div_n", 32'(div_n), 32'd2);
      checkOutput("halt_rst.div_en", 32'(div_en), 32'd0);
      checkOutput("halt_rst.busy", 32'(busy), 32'd0);
      applyStimulus(1'b0, 1'b0, 2'b00, 4'd0, 4'd0);
      checkOutput("halt_rst.after_n", 32'(div_n), 32'd2);

      // Randomized run. Requests are held until served, ratios are biased
      // toward illegal values and toward the current ratio.
      held = 2'b00; hr0 = 4'd0; hr1 = 4'd0;
      for (int i = 0; i < 600; i++) begin
         for (int b = 0; b < 2; b++) begin
            if (!held[b] && ($urandom_range(3) == 0)) begin
               case ($urandom_range(3))
                  0:       pick = 4'($urandom_range(1));
                  1:       pick = 4'(mN);
                  default: pick = 4'($urandom_range(15, 2));
               endcase
               held[b] = 1'b1;
               if (b == 0) hr0 = pick;
               else        hr1 = pick;
            end
         end
         rRst = ($urandom_range(63) == 0);
         rRun = ($urandom_range(15) != 0);
         applyStimulus(rRst, rRun, held, hr0, hr1);
         held = held & ~(mGnt | mRej);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
